// File: rtl/ahblite_busmatrix_arbiter_rr_pkg.sv
// Shared definitions for the bus-matrix output-stage arbiters.
// Holds the AHB-Lite transfer and burst codes, the arbiter FSM encoding,
// the control bundle taken from the granted master, and the burst-length helpers.
package ahblite_busmatrix_arbiter_rr_pkg;

   // HTRANS codes
   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_BUSY   = 2'b01;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;

   // HBURST codes
   localparam logic [2:0] BU_SINGLE = 3'b000;
   localparam logic [2:0] BU_INCR   = 3'b001;
   localparam logic [2:0] BU_WRAP4  = 3'b010;
   localparam logic [2:0] BU_INCR4  = 3'b011;
   localparam logic [2:0] BU_WRAP8  = 3'b100;
   localparam logic [2:0] BU_INCR8  = 3'b101;
   localparam logic [2:0] BU_WRAP16 = 3'b110;
   localparam logic [2:0] BU_INCR16 = 3'b111;

   // Arbiter FSM encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_OWN  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   // Address-phase control of the currently granted master
   typedef struct packed {
      logic       hmastlock;
      logic [2:0] hburst;
      logic [1:0] htrans;
   } ahb_ctrl_t;

   // Beats remaining after the NONSEQ of a fixed-length burst; 0 for SINGLE/INCR
   function automatic logic [3:0] burst_beats_m1(input logic [2:0] hburst);
      logic [3:0] v;
      v = 4'd0;
      case (hburst)
         BU_WRAP4,  BU_INCR4:  v = 4'd3;
         BU_WRAP8,  BU_INCR8:  v = 4'd7;
         BU_WRAP16, BU_INCR16: v = 4'd15;
         BU_SINGLE, BU_INCR:   v = 4'd0;
         default:              v = 4'd0;
      endcase
      return v;
   endfunction

   // True for WRAPx/INCRx bursts with a known beat count
   function automatic logic is_fixed_burst(input logic [2:0] hburst);
      return (hburst[2:1] != 2'b00);
   endfunction

endpackage

// File: rtl/ahblite_busmatrix_arbiter_rr_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   i_req   - request vector, bit i = port i
//   i_ptr   - index of the last granted port; the scan starts one above it
//   o_grant - one-hot winner (all-zero when nothing requests)
//   o_valid - at least one request was found
module ahblite_busmatrix_arbiter_rr_rr_pick #(
   parameter int unsigned N     = 3,
   parameter int unsigned PTR_W = 2
) (
   input  logic [N-1:0]     i_req,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [N-1:0]     o_grant,
   output logic             o_valid
);

   logic w_found;

   // Scan ptr+1, ptr+2, ... wrapping modulo N; first set bit wins
   always_comb begin
      o_grant = '0;
      w_found = 1'b0;
      for (int unsigned k = 1; k <= N; k++) begin
         if (!w_found && i_req[PTR_W'((32'(i_ptr) + k) % N)]) begin
            o_grant[PTR_W'((32'(i_ptr) + k) % N)] = 1'b1;
            w_found = 1'b1;
         end
      end
      o_valid = w_found;
   end

endmodule

// File: rtl/ahblite_busmatrix_arbiter_rr.sv
// Burst-aware round-robin arbiter for one bus-matrix output stage.
// The grant is held across fixed bursts, INCR bursts and locked sequences
// and only moves on HREADY-qualified address-phase boundaries.
// Ports:
//   HCLK, HRESET           - clock, asynchronous active-high reset
//   REQ                    - per-input-stage request vector
//   HREADY_Outputstage     - qualifies every state update
//   HSEL_Outputstage       - current address phase targets this slave
//   HTRANS/HBURST/HMASTLOCK_Outputstage - control of the granted master
//   PORT_SEL               - registered one-hot grant (mux select)
//   PORT_NOSEL             - registered "no port granted"
//   BURST_ACTIVE           - registered "grant is being held"
module ahblite_busmatrix_arbiter_rr
   import ahblite_busmatrix_arbiter_rr_pkg::*;
#(
   parameter int unsigned NUM_PORTS = 3,
   parameter int unsigned CNT_W     = 4
) (
   input  logic                 HCLK,
   input  logic                 HRESET,
   input  logic [NUM_PORTS-1:0] REQ,
   input  logic                 HREADY_Outputstage,
   input  logic                 HSEL_Outputstage,
   input  logic [1:0]           HTRANS_Outputstage,
   input  logic [2:0]           HBURST_Outputstage,
   input  logic                 HMASTLOCK_Outputstage,
   output logic [NUM_PORTS-1:0] PORT_SEL,
   output logic                 PORT_NOSEL,
   output logic                 BURST_ACTIVE
);

   localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   logic [1:0]           r_state,    w_state_nx;
   logic [NUM_PORTS-1:0] r_port_sel, w_sel_nx;
   logic [PTR_W-1:0]     r_ptr,      w_ptr_nx;
   logic [CNT_W-1:0]     r_cnt,      w_cnt_nx;
   logic                 r_nosel;
   logic                 r_burst;
   logic                 w_release;
   logic [NUM_PORTS-1:0] w_pick;
   logic                 w_pick_vld;
   logic [PTR_W-1:0]     w_pick_idx;
   ahb_ctrl_t            w_ctrl;

   assign w_ctrl = '{hmastlock: HMASTLOCK_Outputstage,
                     hburst:    HBURST_Outputstage,
                     htrans:    HTRANS_Outputstage};

   ahblite_busmatrix_arbiter_rr_rr_pick #(
      .N     (NUM_PORTS),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .i_req   (REQ),
      .i_ptr   (r_ptr),
      .o_grant (w_pick),
      .o_valid (w_pick_vld)
   );

   // One-hot winner to index for the last-grant pointer
   always_comb begin
      w_pick_idx = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (w_pick[i]) w_pick_idx = PTR_W'(i);
      end
   end

   // Hold evaluation and re-arbitration
   always_comb begin
      w_state_nx = r_state;
      w_sel_nx   = r_port_sel;
      w_ptr_nx   = r_ptr;
      w_cnt_nx   = r_cnt;
      w_release  = 1'b0;

      if (r_state == ST_IDLE || !HSEL_Outputstage) begin
         w_release = 1'b1;
      end else if (w_ctrl.hmastlock) begin
         // lock overrides everything; other requesters wait
         w_state_nx = ST_HOLD;
      end else begin
         case (w_ctrl.htrans)
            TR_NONSEQ: begin
               // NONSEQ with beats still pending is an early termination
               if (r_cnt != '0 || w_ctrl.hburst == BU_SINGLE) begin
                  w_release = 1'b1;
               end else begin
                  w_cnt_nx   = CNT_W'(burst_beats_m1(w_ctrl.hburst));
                  w_state_nx = ST_HOLD;
               end
            end
            TR_SEQ: begin
               if (is_fixed_burst(w_ctrl.hburst)) begin
                  // old count of 1 (or 0) means this is the last beat
                  if (r_cnt > CNT_W'(1)) begin
                     w_cnt_nx   = r_cnt - CNT_W'(1);
                     w_state_nx = ST_HOLD;
                  end else begin
                     w_release = 1'b1;
                  end
               end else if (w_ctrl.hburst == BU_INCR) begin
                  w_state_nx = ST_HOLD;
               end else begin
                  w_release = 1'b1;
               end
            end
            TR_BUSY: begin
               w_state_nx = ST_HOLD;
            end
            default: begin
               w_release = 1'b1;
            end
         endcase
      end

      if (w_release) begin
         w_cnt_nx = '0;
         if (w_pick_vld) begin
            w_sel_nx   = w_pick;
            w_ptr_nx   = w_pick_idx;
            w_state_nx = ST_OWN;
         end else begin
            w_sel_nx   = '0;
            w_state_nx = ST_IDLE;
         end
      end
   end

   // State and output registers; everything freezes while HREADY is low
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_state    <= ST_IDLE;
         r_port_sel <= '0;
         r_ptr      <= PTR_W'(NUM_PORTS - 1);
         r_cnt      <= '0;
         r_nosel    <= 1'b1;
         r_burst    <= 1'b0;
      end else if (HREADY_Outputstage) begin
         r_state    <= w_state_nx;
         r_port_sel <= w_sel_nx;
         r_ptr      <= w_ptr_nx;
         r_cnt      <= w_cnt_nx;
         r_nosel    <= (w_state_nx == ST_IDLE);
         r_burst    <= (w_state_nx == ST_HOLD);
      end
   end

   assign PORT_SEL     = r_port_sel;
   assign PORT_NOSEL   = r_nosel;
   assign BURST_ACTIVE = r_burst;

endmodule

// File: tb/tb_ahblite_busmatrix_arbiter_rr.sv
// Self-checking bench for ahblite_busmatrix_arbiter_rr: directed scenarios
// followed by randomized master traffic, checked against a burst-level model.
module tb_ahblite_busmatrix_arbiter_rr;
   import ahblite_busmatrix_arbiter_rr_pkg::*;

   localparam int unsigned N     = 3;
   localparam int unsigned CNT_W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req;
   logic         hready, hsel, lock;
   logic [1:0]   htrans;
   logic [2:0]   hburst;
   logic [N-1:0] port_sel;
   logic         nosel, burst_act;

   always #5 clk = ~clk;

   ahblite_busmatrix_arbiter_rr #(.NUM_PORTS(N), .CNT_W(CNT_W)) dut (
      .HCLK                  (clk),
      .HRESET                (rst),
      .REQ                   (req),
      .HREADY_Outputstage    (hready),
      .HSEL_Outputstage      (hsel),
      .HTRANS_Outputstage    (htrans),
      .HBURST_Outputstage    (hburst),
      .HMASTLOCK_Outputstage (lock),
      .PORT_SEL              (port_sel),
      .PORT_NOSEL            (nosel),
      .BURST_ACTIVE          (burst_act)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: owner, last winner, and progress through the current fixed burst
   int m_owner, m_ptr, m_len, m_done;
   bit m_hold;

   function automatic int blen(input logic [2:0] b);
      if (b >= 3'd6) return 16;
      if (b >= 3'd4) return 8;
      if (b >= 3'd2) return 4;
      return 0;
   endfunction

   function automatic void model_reset();
      m_owner = -1;
      m_ptr   = int'(N) - 1;
      m_len   = 0;
      m_done  = 0;
      m_hold  = 1'b0;
   endfunction

   function automatic void model_edge();
      bit rel;
      rel = 1'b0;
      if (!hready) return;
      if (m_owner < 0 || !hsel) rel = 1'b1;
      else if (lock) m_hold = 1'b1;
      else if (htrans == TR_NONSEQ) begin
         if (m_len != 0 || hburst == BU_SINGLE) rel = 1'b1;
         else begin
            m_len  = blen(hburst);
            m_done = (m_len > 0) ? 1 : 0;
            m_hold = 1'b1;
         end
      end else if (htrans == TR_SEQ) begin
         if (blen(hburst) > 0) begin
            if (m_len == 0) rel = 1'b1;
            else begin
               m_done++;
               if (m_done >= m_len) rel = 1'b1;
               else m_hold = 1'b1;
            end
         end else if (hburst == BU_INCR) m_hold = 1'b1;
         else rel = 1'b1;
      end else if (htrans == TR_BUSY) m_hold = 1'b1;
      else rel = 1'b1;

      if (rel) begin
         m_len   = 0;
         m_done  = 0;
         m_hold  = 1'b0;
         m_owner = -1;
         for (int k = 1; k <= int'(N); k++) begin
            int p;
            p = (m_ptr + k) % int'(N);
            if (m_owner < 0 && ((int'(req) >> p) & 1) == 1) begin
               m_owner = p;
               m_ptr   = p;
            end
         end
      end
   endfunction

   function automatic logic [N-1:0] exp_sel();
      if (m_owner < 0) return '0;
      return N'(1) << m_owner;
   endfunction

   task automatic compare_all();
      chk("port_sel",     32'(port_sel),  32'(exp_sel()));
      chk("port_nosel",   32'(nosel),     32'(m_owner < 0));
      chk("burst_active", 32'(burst_act), 32'(m_hold));
   endtask

   // Drive one cycle, let the edge happen, update the model, check
   task automatic step(input logic rdy, input logic [N-1:0] rq, input logic [1:0] tr,
                       input logic [2:0] bu, input logic lk);
      hready = rdy;
      hsel   = 1'b1;
      req    = rq;
      htrans = tr;
      hburst = bu;
      lock   = lk;
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   // Random traffic generator state
   int       g_left, g_lock, prev_owner, r;
   logic [N-1:0] g_rq;
   logic [1:0]   g_tr;
   logic [2:0]   g_bu, g_burst;
   logic         g_rdy, g_sel, g_lk;

   initial begin
      rst = 1'b1; req = '0; hready = 1'b1; hsel = 1'b1;
      htrans = TR_IDLE; hburst = BU_SINGLE; lock = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_sel",   32'(port_sel),  32'd0);
      chk("reset_nosel", 32'(nosel),     32'd1);
      chk("reset_burst", 32'(burst_act), 32'd0);
      rst = 1'b0;

      // Fairness: SINGLE transfers with all ports requesting
      step(1'b1, 3'b111, TR_NONSEQ, BU_SINGLE, 1'b0); chk("fair_0", 32'(port_sel), 32'b001);
      step(1'b1, 3'b111, TR_NONSEQ, BU_SINGLE, 1'b0); chk("fair_1", 32'(port_sel), 32'b010);
      step(1'b1, 3'b111, TR_NONSEQ, BU_SINGLE, 1'b0); chk("fair_2", 32'(port_sel), 32'b100);
      step(1'b1, 3'b111, TR_NONSEQ, BU_SINGLE, 1'b0); chk("fair_3", 32'(port_sel), 32'b001);

      // Port1 INCR8 holds the grant for all 8 beats
      step(1'b1, 3'b111, TR_NONSEQ, BU_SINGLE, 1'b0); chk("incr8_grant", 32'(port_sel), 32'b010);
      step(1'b1, 3'b111, TR_NONSEQ, BU_INCR8, 1'b0);
      chk("incr8_hold", 32'(burst_act), 32'd1);
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 3'b111, TR_SEQ, BU_INCR8, 1'b0);
         chk("incr8_beat", 32'(port_sel), 32'b010);
      end
      step(1'b1, 3'b111, TR_SEQ, BU_INCR8, 1'b0);
      chk("incr8_last", 32'(port_sel), 32'b100);
      chk("incr8_rel",  32'(burst_act), 32'd0);

      // Port0 INCR4 with three wait states on beat 2
      step(1'b1, 3'b111, TR_NONSEQ, BU_SINGLE, 1'b0); chk("incr4_grant", 32'(port_sel), 32'b001);
      step(1'b1, 3'b111, TR_NONSEQ, BU_INCR4, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 3'b111, TR_SEQ, BU_INCR4, 1'b0);
         chk("wait_frozen", 32'(port_sel), 32'b001);
      end
      step(1'b1, 3'b111, TR_SEQ, BU_INCR4, 1'b0);
      step(1'b1, 3'b111, TR_SEQ, BU_INCR4, 1'b0);
      chk("incr4_beat3", 32'(port_sel), 32'b001);
      step(1'b1, 3'b111, TR_SEQ, BU_INCR4, 1'b0);
      chk("incr4_done", 32'(port_sel), 32'b010);

      // Port2 WRAP16 terminated with IDLE after 5 beats
      step(1'b1, 3'b111, TR_NONSEQ, BU_SINGLE, 1'b0); chk("wrap16_grant", 32'(port_sel), 32'b100);
      step(1'b1, 3'b111, TR_NONSEQ, BU_WRAP16, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 3'b111, TR_SEQ, BU_WRAP16, 1'b0);
      chk("wrap16_held", 32'(port_sel), 32'b100);
      step(1'b1, 3'b111, TR_IDLE, BU_WRAP16, 1'b0);
      chk("early_term_sel",   32'(port_sel),  32'b001);
      chk("early_term_burst", 32'(burst_act), 32'd0);

      // Port0 locked across two SINGLEs
      step(1'b1, 3'b111, TR_NONSEQ, BU_SINGLE, 1'b1); chk("lock_0", 32'(port_sel), 32'b001);
      step(1'b1, 3'b111, TR_NONSEQ, BU_SINGLE, 1'b1); chk("lock_1", 32'(port_sel), 32'b001);
      step(1'b1, 3'b111, TR_NONSEQ, BU_SINGLE, 1'b0); chk("unlock", 32'(port_sel), 32'b010);

      // Asynchronous reset in the middle of a burst
      step(1'b1, 3'b111, TR_NONSEQ, BU_INCR16, 1'b0);
      step(1'b1, 3'b111, TR_SEQ, BU_INCR16, 1'b0);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_sel",   32'(port_sel),  32'd0);
      chk("async_rst_nosel", 32'(nosel),     32'd1);
      chk("async_rst_burst", 32'(burst_act), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      g_left = 0; g_lock = 0; g_burst = BU_SINGLE;

      // Randomized traffic from whichever master holds the grant
      for (int c = 0; c < 3000; c++) begin
         g_rdy = ($urandom_range(0, 5) != 0);
         g_sel = ($urandom_range(0, 40) != 0);
         g_rq  = N'($urandom);
         if ($urandom_range(0, 3) == 0) g_rq = '1;
         if (g_lock == 0 && $urandom_range(0, 40) == 0) g_lock = int'($urandom_range(1, 4));
         g_lk = (g_lock > 0);
         if (g_left > 0) begin
            r = int'($urandom_range(0, 19));
            g_bu = g_burst;
            if (r == 0)      g_tr = TR_IDLE;
            else if (r == 1) begin g_tr = TR_NONSEQ; g_bu = 3'($urandom_range(0, 7)); end
            else if (r < 4)  g_tr = TR_BUSY;
            else             g_tr = TR_SEQ;
         end else begin
            g_tr = ($urandom_range(0, 2) == 0) ? TR_IDLE : TR_NONSEQ;
            g_bu = 3'($urandom_range(0, 7));
         end
         prev_owner = m_owner;
         hready = g_rdy; hsel = g_sel; req = g_rq;
         htrans = g_tr;  hburst = g_bu; lock = g_lk;
         @(posedge clk);
         model_edge();
         #1;
         compare_all();
         if (g_rdy) begin
            if (g_tr == TR_SEQ && g_left > 0) g_left--;
            else if (g_tr == TR_IDLE) g_left = 0;
            else if (g_tr == TR_NONSEQ) begin
               g_burst = g_bu;
               if (g_bu == BU_SINGLE)   g_left = 0;
               else if (g_bu == BU_INCR) g_left = int'($urandom_range(0, 5));
               else                      g_left = blen(g_bu) - 1;
            end
            if (g_lock > 0) g_lock--;
         end
         if (m_owner != prev_owner) g_left = 0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
